// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Brief    : Shared types and sizes for reg_file_arbiter and its sub-modules.
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

    localparam int RF_ADDR_W = 8;
    localparam int RF_DATA_W = 8;
    // Widest response ID the arbiter supports (NUM_REQ up to 8).
    localparam int MAX_ID_W  = 3;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] wdata;
    } rf_op_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } rsp_tag_t;

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/reg_file_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotate-and-priority-encode; one-hot grant plus the
//            encoded index of the first request at or above i_ptr (wrapping).
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx
);

    localparam logic [ID_W:0] C_NUM_REQ = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0] w_pos;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // i_ptr < NUM_REQ, so one conditional subtract implements the wrap.
            w_pos = {1'b0, i_ptr} + (ID_W+1)'(i);
            if (w_pos >= C_NUM_REQ) begin
                w_pos = w_pos - C_NUM_REQ;
            end
            if (!w_found && i_req[w_pos[ID_W-1:0]]) begin
                w_found                  = 1'b1;
                o_gnt[w_pos[ID_W-1:0]]   = 1'b1;
                o_idx                    = w_pos[ID_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_arbiter
// Brief    : Shares the register-file write port and r1 read port among
//            NUM_REQ requesters; one op per cycle, 2-cycle read latency.
//            Define REG_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*RF_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*RF_DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [RF_DATA_W-1:0]           rsp_data,
    output logic [RF_ADDR_W-1:0]           rf_r1_addr,
    output logic [RF_ADDR_W-1:0]           rf_write_addr,
    output logic [RF_DATA_W-1:0]           rf_write_data,
    output logic                           rf_write_ctrl,
    input  logic [RF_DATA_W-1:0]           rf_r1_out
);

    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [ID_W-1:0]      w_idx;
    logic [ID_W-1:0]      w_ptr;
    logic                 w_accept;
    rf_op_t               w_op;
    logic [MAX_ID_W-1:0]  w_issue_id;

    logic [RF_ADDR_W-1:0] r_r1_addr;
    logic [RF_ADDR_W-1:0] r_wr_addr;
    logic [RF_DATA_W-1:0] r_wr_data;
    logic                 r_wr_ctrl;
    rsp_tag_t             r_issue_tag;
    rsp_tag_t             r_rsp_tag;

`ifdef REG_ARB_FIXED_PRIO_EN
    // Rotation by zero degenerates to a plain lowest-index priority encoder.
    assign w_ptr = '0;
`else
    localparam logic [ID_W-1:0] C_LAST = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] r_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_idx == C_LAST) ? '0 : w_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (w_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_idx)
    );

    assign gnt      = w_pick_gnt & {NUM_REQ{reset_n}};
    assign w_accept = |gnt;

    always_comb begin
        w_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                w_op.we    = req_we[i];
                w_op.addr  = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
                w_op.wdata = req_wdata[i*RF_DATA_W +: RF_DATA_W];
            end
        end
    end

    always_comb begin
        w_issue_id             = '0;
        w_issue_id[ID_W-1:0]   = w_idx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ctrl <= 1'b0;
            r_r1_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_ctrl <= w_accept & w_op.we;
            if (w_accept && w_op.we) begin
                r_wr_addr <= w_op.addr;
                r_wr_data <= w_op.wdata;
            end
            if (w_accept && !w_op.we) begin
                r_r1_addr <= w_op.addr;
            end
        end
    end

    // Tag pipeline tracks the register file's one-cycle read capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_issue_tag <= '0;
            r_rsp_tag   <= '0;
        end else begin
            r_issue_tag.valid <= w_accept & ~w_op.we;
            r_issue_tag.id    <= w_issue_id;
            r_rsp_tag         <= r_issue_tag;
        end
    end

    assign rf_write_ctrl = r_wr_ctrl;
    assign rf_write_addr = r_wr_addr;
    assign rf_write_data = r_wr_data;
    assign rf_r1_addr    = r_r1_addr;
    assign rsp_valid     = r_rsp_tag.valid;
    assign rsp_id        = r_rsp_tag.id[ID_W-1:0];
    assign rsp_data      = rf_r1_out;

endmodule : reg_file_arbiter
`default_nettype wire

// File: tb/tb_reg_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_arbiter
// Brief    : Directed self-checking bench for reg_file_arbiter with a simple
//            register-file model (write before read, registered r1_out).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_arbiter;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [7:0]  rf_r1_addr;
    logic [7:0]  rf_write_addr;
    logic [7:0]  rf_write_data;
    logic        rf_write_ctrl;
    logic [7:0]  rf_r1_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    reg_file_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rf_r1_addr    (rf_r1_addr),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_write_ctrl (rf_write_ctrl),
        .rf_r1_out     (rf_r1_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file model: write lands before the read capture of the same edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        rf_r1_out = 8'h00;
    end
    always @(posedge clock) begin
        if (rf_write_ctrl) mem[rf_write_addr] = rf_write_data;
        rf_r1_out <= mem[rf_r1_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'(8'h50 + i), 8'h00);
        tick();
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (rf_write_ctrl !== 1'b0) begin errors++; $display("FAIL rst_wctrl got=%b exp=0", rf_write_ctrl); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if ({rf_r1_addr, rf_write_addr, rf_write_data} !== 24'h0) begin errors++;
            $display("FAIL rst_regs got=%h exp=000000", {rf_r1_addr, rf_write_addr, rf_write_data}); end
        reset_n = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt got=%b exp=0001", gnt); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_write_then_read();
        drive(2, 1'b1, 8'h10, 8'hA5);
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt got=%b exp=0100", gnt); end
        tick();
        req = 4'b0000;
        drive(0, 1'b0, 8'h10, 8'h00);
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rd_gnt got=%b exp=0001", gnt); end
        checks++; if ({rf_write_ctrl, rf_write_addr, rf_write_data} !== {1'b1, 8'h10, 8'hA5}) begin errors++;
            $display("FAIL wr_issue got=%b/%h/%h exp=1/10/a5", rf_write_ctrl, rf_write_addr, rf_write_data); end
        tick();
        req = 4'b0000;
        #1;
        checks++; if ({rf_write_ctrl, rf_r1_addr, rsp_valid} !== {1'b0, 8'h10, 1'b0}) begin errors++;
            $display("FAIL rd_issue got=%b/%h/%b exp=0/10/0", rf_write_ctrl, rf_r1_addr, rsp_valid); end
        tick();
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 8'hA5}) begin errors++;
            $display("FAIL wr_rd_rsp got=%b/%0d/%h exp=1/0/a5", rsp_valid, rsp_id, rsp_data); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_pulse got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
        // Requester 3 alone moves the pointer back to 0.
        drive(3, 1'b0, 8'h23, 8'h00);
        tick();
        req = 4'b0000;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'(8'h20 + i), 8'h00);
        for (int c = 0; c < 11; c++) begin
            if (c == 8) req = 4'b0000;
            #1;
            if (c < 8) begin
                exp_gnt = 4'(1 << (c % 4));
                checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
            end
            if (c >= 2 && c < 10) begin
                exp_id = 2'((c - 2) % 4);
                checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, exp_id, (8'h20 + 8'(exp_id)) ^ 8'h3C}) begin errors++;
                    $display("FAIL rr_rsp c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, rsp_valid, rsp_id, rsp_data,
                             exp_id, (8'h20 + 8'(exp_id)) ^ 8'h3C); end
            end
            if (c == 10) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_tail got=%b exp=0", rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_sparse_wrap();
        drive(2, 1'b0, 8'h02, 8'h00);
        tick();
        req = 4'b0000;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 8'h02, 8'h00);
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt_0101 got=%b exp=0001", gnt); end
        tick();
        req = 4'b0100;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_gnt_0100 got=%b exp=0100", gnt); end
        tick();
        req = 4'b1001;
        drive(3, 1'b0, 8'h03, 8'h00);
        #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt_1001 got=%b exp=1000", gnt); end
        tick();
        req = 4'b0011;
        drive(1, 1'b0, 8'h01, 8'h00);
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt_0011 got=%b exp=0001", gnt); end
        tick();
        req = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_midflight();
        req = 4'b0000;
        drive(0, 1'b0, 8'h20, 8'h00);
        tick();
        req = 4'b0000;
        drive(1, 1'b1, 8'h30, 8'hEE);
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_wr_gnt got=%b exp=0010", gnt); end
        tick();
        req = 4'b0000;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_rsp got=%b exp=1", rsp_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, rf_write_ctrl, gnt} !== 6'b0) begin errors++;
            $display("FAIL mid_rst got=%b/%b/%b exp=0/0/0000", rsp_valid, rf_write_ctrl, gnt); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got=%b exp=0", rsp_valid); end
        reset_n = 1'b1;
        tick();
        drive(0, 1'b0, 8'h30, 8'h00);
        tick();
        req = 4'b0000;
        tick();
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 8'h0C}) begin errors++;
            $display("FAIL mid_cancelled_wr got=%b/%0d/%h exp=1/0/0c", rsp_valid, rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_hold_pair();
        logic [3:0] exp_gnt [3];
`ifdef REG_ARB_FIXED_PRIO_EN
        exp_gnt = '{4'b0010, 4'b0010, 4'b0010};
`else
        exp_gnt = '{4'b0010, 4'b0100, 4'b0010};
`endif
        req = 4'b0000;
        drive(1, 1'b0, 8'h41, 8'h00);
        drive(2, 1'b0, 8'h42, 8'h00);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (gnt !== exp_gnt[c]) begin errors++; $display("FAIL hold_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt[c]); end
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 4'b0000;
        req_we    = 4'b0000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #1;
        test_reset();
        test_write_then_read();
`ifndef REG_ARB_FIXED_PRIO_EN
        test_round_robin();
        test_sparse_wrap();
`endif
        test_reset_midflight();
        test_hold_pair();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_arbiter
`default_nettype wire

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Round-robin arbiter that shares the single write port and the r1 read port of the 8-bit register file between NUM_REQ independent requesters. Each cycle it accepts at most one operation (read or write), drives it onto the register-file ports through one register stage, and returns read data to the owning requester tagged with its ID. It sits between the requesters and the register file; the register file's r2 port is not used by this block.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of the response ID; must equal ceil(log2(NUM_REQ)).
- clock  in  1  rising-edge clock, shared with the register file.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  per-requester operation: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*8  per-requester address; requester i uses bits [8i+7:8i].
- req_wdata  in  NUM_REQ*8  per-requester write data, packed the same way as req_addr.
- gnt  out  NUM_REQ  one-hot combinational grant; req[i] & gnt[i] means the operation is accepted this cycle.
- rsp_valid  out  1  read data valid.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  8  read data.
- rf_r1_addr  out  8  to the register file r1_addr.
- rf_write_addr  out  8  to the register file write_addr.
- rf_write_data  out  8  to the register file write_data.
- rf_write_ctrl  out  1  to the register file write_ctrl.
- rf_r1_out  in  8  from the register file r1_out.

## Operation
- **Grant.** gnt is zero when req is zero.
  - Otherwise gnt selects the first asserted req at or after the round-robin pointer ptr, searching upward with wrap-around.
- **Pointer update.** On acceptance of requester k, ptr becomes (k+1) mod NUM_REQ. With no acceptance, ptr holds.
- **Requester rule.** A requester holds req, req_we, req_addr and req_wdata stable until it sees gnt. It may deassert req only after acceptance.
- **Issue stage (registered, updated every edge).**
  - Accepted write: rf_write_ctrl=1, rf_write_addr and rf_write_data taken from the accepted requester.
  - Accepted read: rf_write_ctrl=0, rf_r1_addr taken from the accepted requester.
  - No acceptance: rf_write_ctrl=0. Address and data registers hold their values.
- **Response pipeline.**
  - Two valid/ID register stages: the issue stage and the response stage.
  - The issue stage is set only for accepted reads.
  - rsp_valid and rsp_id come from the response stage.
  - rsp_data is rf_r1_out passed through combinationally.
- **Write-then-read ordering.** A read accepted in any cycle after a write's acceptance returns the new data. The register file writes before it reads within the same edge.
- **Throughput.** One operation per cycle; reads and writes are never issued in the same cycle.
- **Reset values.**
  - gnt is 0 while reset_n=0.
  - ptr=0, rf_write_ctrl=0, rf_r1_addr=0, rf_write_addr=0, rf_write_data=0.
  - Both valid stages 0, rsp_valid=0, rsp_id=0.
- **Reset mid-operation.** Asserting reset_n drops in-flight reads with no response. rf_write_ctrl clears asynchronously, so an issued-but-unsampled write is cancelled.

## Timing
- **Cycle T:** req[k] & gnt[k] are high.
- **Edge at end of T:** the issue registers load.
- **Cycle T+1:** the register file sees the address. Its edge at the end of T+1 performs the write, or captures the read.
- **Read response:** rsp_valid=1, rsp_id=k, rsp_data valid in cycle T+2. Read latency is 2 cycles, with no stalls.
- **Write visibility:** a write accepted in T is visible to a read accepted in T+1 or later.
- **Back-to-back reads:** reads accepted in consecutive cycles produce responses in consecutive cycles, in acceptance order.
- **Response timing:** rsp_valid is a single-cycle pulse per read. There is no backpressure, so requesters must sample rsp in the cycle it is valid.

## Configuration
- **REG_ARB_FIXED_PRIO_EN defined:** fixed priority replaces round-robin. The lowest asserted index always wins, and ptr is not implemented.
- **REG_ARB_FIXED_PRIO_EN undefined (default):** round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- **Package reg_arb_pkg:**
  - localparam RF_ADDR_W=8 and RF_DATA_W=8.
  - typedef rf_op_t (we, addr, wdata).
  - typedef rsp_tag_t (valid, id).
- **Sub-module rr_pick:** a combinational rotate-and-priority-encode that produces the one-hot grant and encoded index from req and ptr. It is instantiated once, and bypassed to a plain priority encoder under REG_ARB_FIXED_PRIO_EN.

## Test plan
- **Reset:** reset_n=0 with req=4'b1111 -> gnt=0, rf_write_ctrl=0, rsp_valid=0. After release, the first grant is gnt=4'b0001.
- **Write then read:** requester 2 writes addr 0x10, data 0xA5 in cycle T; requester 0 reads 0x10 in T+1 -> rsp_valid in T+3, rsp_id=0, rsp_data=0xA5.
- **Round-robin fairness:** all four requesters read continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order, 2 cycles after each grant, with no gaps.
- **Sparse wrap-around:** ptr=3 with req=4'b0101 -> gnt=4'b0001, then ptr=1. Next cycle, req=4'b0100 -> gnt=4'b0100.
- **Reset mid-flight:** two reads accepted in cycles T and T+1, reset asserted in T+2 -> no rsp_valid. A write issued in the same window does not change the register contents.
- **REG_ARB_FIXED_PRIO_EN build:** req=4'b0110 held for 3 cycles (requesters keep re-requesting) -> gnt=4'b0010 every cycle; requester 2 is starved as specified.
